// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 camera capture path: default frame
// geometry, frame buffer address width and the capture FSM state type.
package cam_pkg;

    localparam int CAM_H_RES  = 320;
    localparam int CAM_V_RES  = 240;
    localparam int CAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_FRAME,
        CAPTURE,
        SKIP
    } cap_state_t;

endpackage

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 write-side controller: decodes VSYNC/HREF/byte stream in the PCLK
// domain, packs byte pairs into RGB565 pixels and writes them to the frame buffer.
module ov7670_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_RES  = CAM_H_RES,
    parameter int V_RES  = CAM_V_RES,
    parameter int ADDR_W = CAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cap_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    // Counters get one spare code above the limit so overruns stay visible.
    localparam int XW = $clog2(H_RES + 2);
    localparam int YW = $clog2(V_RES + 2);
    localparam logic [XW-1:0]     X_LIM     = XW'(H_RES);
    localparam logic [YW-1:0]     Y_LIM     = YW'(V_RES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    cap_state_t        state;
    logic              vs_r, vs_p, href_r, href_p;
    logic [7:0]        data_r;
    logic [7:0]        hi_byte;
    logic              phase;
    logic [XW-1:0]     x;
    logic [YW-1:0]     line_cnt;
    logic [ADDR_W-1:0] line_base;
    logic              err_flag;

    logic              vs_rise, vs_fall, line_start, line_end, line_bad, frame_clean;
    logic [YW-1:0]     lines_seen;

    always_comb begin
        vs_rise     = vs_r & ~vs_p;
        vs_fall     = ~vs_r & vs_p;
        line_start  = href_r & ~href_p;
        line_end    = ~href_r & href_p;
        line_bad    = line_end & ((x != X_LIM) | phase);
        // A line ending in the same cycle as the frame end still counts.
        lines_seen  = line_end ? line_cnt + YW'(1) : line_cnt;
        frame_clean = ~err_flag & ~line_bad & ~href_r & (lines_seen == Y_LIM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_VS;
            vs_r       <= 1'b0;
            vs_p       <= 1'b0;
            href_r     <= 1'b0;
            href_p     <= 1'b0;
            data_r     <= '0;
            hi_byte    <= '0;
            phase      <= 1'b0;
            x          <= '0;
            line_cnt   <= '0;
            line_base  <= '0;
            err_flag   <= 1'b0;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vs_r       <= vsync;
            vs_p       <= vs_r;
            href_r     <= href;
            href_p     <= href_r;
            data_r     <= data;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                WAIT_VS: begin
                    if (vs_rise) state <= WAIT_FRAME;
                end

                WAIT_FRAME: begin
                    if (vs_fall) begin
                        state     <= cap_en ? CAPTURE : SKIP;
                        busy      <= cap_en;
                        x         <= '0;
                        line_cnt  <= '0;
                        line_base <= '0;
                        phase     <= 1'b0;
                        err_flag  <= 1'b0;
                    end
                end

                SKIP: begin
                    if (vs_rise) state <= WAIT_FRAME;
                end

                CAPTURE: begin
                    if (vs_rise) begin
                        // Any half-pixel still pending is dropped here.
                        state <= WAIT_FRAME;
                        busy  <= 1'b0;
                        phase <= 1'b0;
                        if (frame_clean) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (href_r) begin
                            phase <= ~phase;
                            if (!phase) begin
                                hi_byte <= data_r;
                            end else begin
                                if (x < X_LIM && line_cnt < Y_LIM) begin
                                    we    <= 1'b1;
                                    wAddr <= line_base + ADDR_W'(x);
                                    wData <= {hi_byte, data_r};
                                end
                                if (x <= X_LIM) x <= x + XW'(1);
                            end
                            if (line_start && line_cnt >= Y_LIM) err_flag <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                        end

                        if (line_end) begin
                            if (line_bad) err_flag <= 1'b1;
                            x         <= '0;
                            line_base <= line_base + LINE_STEP;
                            if (line_cnt <= Y_LIM) line_cnt <= line_cnt + YW'(1);
                        end
                    end
                end

                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench for ov7670_capture_ctrl on a reduced 16x12 frame so whole
// frames (clean, skipped, short/long/extra lines, mid-frame reset) fit in a short run.
module tb_ov7670_capture_ctrl;

    localparam int H    = 16;
    localparam int V    = 12;
    localparam int AW   = 8;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cap_en = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          we;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic [7:0]    frame_cnt;

    int checks = 0;
    int errors = 0;
    int rst_mark = 0;

    logic [AW-1:0] wa_q[$];
    logic [15:0]   wd_q[$];
    int            done_n = 0;
    int            err_n = 0;
    int            both_n = 0;
    int            b2b_n = 0;
    logic          we_d = 1'b0;

    always #5 clk = ~clk;

    ov7670_capture_ctrl #(
        .H_RES (H),
        .V_RES (V),
        .ADDR_W(AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cap_en    (cap_en),
        .vsync     (vsync),
        .href      (href),
        .data      (data),
        .we        (we),
        .wAddr     (wAddr),
        .wData     (wData),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(wAddr);
            wd_q.push_back(wData);
        end
        if (we && we_d) b2b_n <= b2b_n + 1;
        if (frame_done) done_n <= done_n + 1;
        if (frame_err) err_n <= err_n + 1;
        if (frame_done && frame_err) both_n <= both_n + 1;
        we_d <= we;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Even pixels carry A5,3C and odd pixels 5A,C3 so byte order and x are both visible.
    function automatic logic [7:0] pix_byte(input int b);
        int px;
        px = b / 2;
        if (px % 2 == 0) return (b % 2 == 0) ? 8'hA5 : 8'h3C;
        return (b % 2 == 0) ? 8'h5A : 8'hC3;
    endfunction

    task automatic send_line(input int nbytes, input int rst_byte);
        for (int b = 0; b < nbytes; b++) begin
            @(negedge clk);
            href = 1'b1;
            data = pix_byte(b);
            if (b == rst_byte) begin
                reset_n = 1'b0;
                #1;
                check("rst_we", we, 0);
                check("rst_addr", wAddr, 0);
                check("rst_data", wData, 0);
                check("rst_busy", busy, 0);
                check("rst_cnt", frame_cnt, 0);
                rst_mark = wa_q.size();
            end else begin
                reset_n = 1'b1;
            end
        end
        @(negedge clk);
        href    = 1'b0;
        data    = 8'h00;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int nlines, input int short_line, input int short_bytes,
                              input int long_line, input int long_bytes,
                              input int rst_line, input int rst_byte, input int cap_line);
        repeat (3) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            int nb;
            nb = 2 * H;
            if (l == short_line) nb = short_bytes;
            if (l == long_line) nb = long_bytes;
            if (l == cap_line) cap_en = 1'b1;
            send_line(nb, (l == rst_line) ? rst_byte : -1);
        end
    endtask

    // VSYNC pulse: ends the running frame (pulse checked 2 cycles after the pin rises)
    // and starts the next one on its falling edge with the cap_en currently driven.
    task automatic vs_pulse(input string tag, input int exp_done, input int exp_err,
                            input int exp_busy);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        check({tag, "_busy_before"}, busy, exp_busy);
        check({tag, "_early"}, frame_done | frame_err, 0);
        @(negedge clk);
        check({tag, "_done"}, frame_done, exp_done);
        check({tag, "_err"}, frame_err, exp_err);
        check({tag, "_busy_after"}, busy, 0);
        @(negedge clk);
        check({tag, "_one_cycle"}, frame_done | frame_err, 0);
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        $display("vsync %s done=%0d err=%0d frame_cnt=%0d", tag, exp_done, exp_err, frame_cnt);
    endtask

    task automatic check_frame(input string tag, input int base, input int exp_n,
                               input int gap_at, input int gap);
        int n;
        int abad;
        int dbad;
        n    = wa_q.size() - base;
        abad = 0;
        dbad = 0;
        check({tag, "_writes"}, n, exp_n);
        for (int i = 0; i < n; i++) begin
            int          ea;
            logic [15:0] ed;
            ea = (i < gap_at) ? i : i + gap;
            ed = ((int'(wa_q[base + i]) % H) % 2 == 0) ? 16'hA53C : 16'h5AC3;
            if (int'(wa_q[base + i]) != ea) abad++;
            if (wd_q[base + i] != ed) dbad++;
        end
        check({tag, "_addr_seq"}, abad, 0);
        check({tag, "_data"}, dbad, 0);
        $display("frame %s writes=%0d addr_bad=%0d data_bad=%0d", tag, n, abad, dbad);
    endtask

    initial begin
        int base;

        repeat (3) @(negedge clk);
        check("reset_we", we, 0);
        check("reset_addr", wAddr, 0);
        check("reset_data", wData, 0);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", frame_err, 0);
        check("reset_cnt", frame_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Two clean frames
        cap_en = 1'b1;
        vs_pulse("start", 0, 0, 0);
        base = wa_q.size();
        send_frame(V, -1, 0, -1, 0, -1, -1, -1);
        check_frame("clean1", base, NPIX, NPIX, 0);
        vs_pulse("clean1", 1, 0, 1);
        check("cnt_after_clean1", frame_cnt, 1);

        base = wa_q.size();
        send_frame(V, -1, 0, -1, 0, -1, -1, -1);
        check_frame("clean2", base, NPIX, NPIX, 0);
        cap_en = 1'b0;
        vs_pulse("clean2", 1, 0, 1);
        check("cnt_after_clean2", frame_cnt, 2);

        // Disarmed at frame start, armed mid-frame: nothing captured
        base = wa_q.size();
        send_frame(V, -1, 0, -1, 0, -1, -1, 2);
        check("skip_writes", wa_q.size() - base, 0);
        vs_pulse("skip", 0, 0, 0);
        check("cnt_after_skip", frame_cnt, 2);

        base = wa_q.size();
        send_frame(V, -1, 0, -1, 0, -1, -1, -1);
        check_frame("rearmed", base, NPIX, NPIX, 0);
        vs_pulse("rearmed", 1, 0, 1);
        check("cnt_after_rearmed", frame_cnt, 3);

        // Line 5 two pixels short: line 6 still starts at 6*H
        base = wa_q.size();
        send_frame(V, 5, 2 * H - 4, -1, 0, -1, -1, -1);
        check_frame("short", base, NPIX - 2, 6 * H - 2, 2);
        if (wa_q.size() >= base + 6 * H - 1)
            check("short_line6_addr", wa_q[base + 6 * H - 2], 6 * H);
        else
            check("short_line6_present", wa_q.size() - base, 6 * H - 1);
        vs_pulse("short", 0, 1, 1);
        check("cnt_after_short", frame_cnt, 3);

        // Line 3 with 4*H+1 bytes: only H writes on that line
        base = wa_q.size();
        send_frame(V, -1, 0, 3, 4 * H + 1, -1, -1, -1);
        check_frame("long", base, NPIX, NPIX, 0);
        vs_pulse("long", 0, 1, 1);
        check("cnt_after_long", frame_cnt, 3);

        // One extra line: nothing written past the frame
        base = wa_q.size();
        send_frame(V + 1, -1, 0, -1, 0, -1, -1, -1);
        check_frame("extra_line", base, NPIX, NPIX, 0);
        vs_pulse("extra_line", 0, 1, 1);
        check("cnt_after_extra", frame_cnt, 3);

        // Reset in the middle of line 6
        send_frame(V, -1, 0, -1, 0, 6, 9, -1);
        check("rst_no_writes", wa_q.size() - rst_mark, 0);
        vs_pulse("after_rst", 0, 0, 0);
        check("cnt_after_rst", frame_cnt, 0);

        base = wa_q.size();
        send_frame(V, -1, 0, -1, 0, -1, -1, -1);
        check_frame("post_rst", base, NPIX, NPIX, 0);
        vs_pulse("post_rst", 1, 0, 1);
        check("cnt_post_rst", frame_cnt, 1);

        @(negedge clk);
        check("total_done", done_n, 4);
        check("total_err", err_n, 3);
        check("done_err_overlap", both_n, 0);
        check("we_back_to_back", b2b_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_ctrl.md
# ov7670_capture_ctrl

Write-side controller for the 320×240 RGB565 frame buffer.
- Runs in the camera pixel-clock domain and decodes OV7670 VSYNC/HREF/byte stream.
- Assembles byte pairs into 16-bit pixels and drives the frame buffer write port (`we`, `wAddr`, `wData`).
- Gates capture on a per-frame arm signal and reports frame completion or framing errors to game logic, after synchronisation.

## Interface
- `H_RES`, default 320: pixels per line.
- `V_RES`, default 240: lines per frame.
- `ADDR_W`, default 17: write address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES.
- `clk` in 1: OV7670 PCLK. Single clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cap_en` in 1: arm capture; sampled only at frame start.
- `vsync` in 1: OV7670 VSYNC, high during vertical blanking.
- `href` in 1: OV7670 HREF, high while line bytes are valid.
- `data` in 8: OV7670 pixel byte.
- `we` out 1: frame buffer write enable.
- `wAddr` out ADDR_W: frame buffer write address.
- `wData` out 16: RGB565 pixel, `{first byte, second byte}`.
- `busy` out 1: high while in CAPTURE.
- `frame_done` out 1: one-cycle pulse when a complete, clean frame has been written.
- `frame_err` out 1: one-cycle pulse when a captured frame had framing errors.
- `frame_cnt` out 8: count of clean frames; wraps 255→0.

## Operation
- **Registered inputs.** `vsync`, `href` and `data` are registered once. Edge detection uses the registered and previous-registered values.
- **FSM states:** WAIT_VS, WAIT_FRAME, CAPTURE, SKIP.
  - Reset enters WAIT_VS.
  - WAIT_VS: wait for a `vsync` rising edge, then go to WAIT_FRAME. This discards any partial frame after reset.
  - WAIT_FRAME: on a `vsync` falling edge, go to CAPTURE if `cap_en` is 1, else to SKIP. Counters and the error flag clear on this edge.
  - SKIP: `we` stays 0. On a `vsync` rising edge, go to WAIT_FRAME.
  - CAPTURE: on a `vsync` rising edge, end the frame and go to WAIT_FRAME.
- **Frame end (CAPTURE → WAIT_FRAME):**
  - Pulse `frame_done` and increment `frame_cnt` if line_cnt == V_RES and the error flag is clear.
  - Otherwise pulse `frame_err`.
- **Byte assembly.**
  - A phase bit toggles on each registered byte while `href` is high.
  - Phase 0: store the byte as the high byte.
  - Phase 1: form the pixel, issue the write, increment x.
  - Phase clears whenever `href` is low.
- **Address generation.**
  - `wAddr` = line_base + x.
  - On each `href` falling edge, line_base += H_RES and line_cnt++, regardless of x.
  - A short line therefore never shifts later lines.
  - No multiplier.
- **Write suppression.** No write is issued when x ≥ H_RES or line_cnt ≥ V_RES.
- **Error flag.** Set by any of:
  - `href` falls with x ≠ H_RES.
  - `href` falls with the phase bit at 1 (odd byte count).
  - A line starts with line_cnt ≥ V_RES.
- **Arming.** `cap_en` changes mid-frame have no effect until the next frame start.

## Timing
- **Reset values:** all outputs 0; FSM in WAIT_VS; internal counters 0.
- **Write latency:** the phase-1 byte presented at `data` on edge N produces `we`=1 with matching `wData`/`wAddr` during the cycle after edge N+1. That is 2 cycles: input register plus output register.
- **Write rate:** `we` is a one-cycle pulse, at most every other cycle.
- **Frame-end pulses:** `frame_done`/`frame_err` assert 2 cycles after the `vsync` rising edge at the pins. `frame_done` and `frame_err` are mutually exclusive.
- **`frame_cnt`:** updates in the same cycle as `frame_done`.
- **`busy`:** tracks the CAPTURE state registered; it drops in the cycle the frame-end pulse asserts.
- **Simultaneous events:**
  - If a `vsync` rising edge coincides with `href` high, the frame ends. The pending half-pixel is dropped, the error flag is set, and `frame_err` is pulsed.
- **Reset mid-frame:** outputs return to 0 immediately (asynchronous). No pulse is emitted. Capture resumes only after a full VSYNC pulse.

## Structure
- **Shared package `cam_pkg`:**
  - `H_RES`/`V_RES` defaults.
  - `ADDR_W`.
  - `cap_state_t` enum {WAIT_VS, WAIT_FRAME, CAPTURE, SKIP}.
- **Sub-modules:** none. Edge detection and counters stay inline; the block is a single FSM plus datapath.

## Test plan
- Reset, then 2 clean frames of 320×240 with `cap_en`=1.
  - Required: 76800 writes per frame, addresses 0..76799 in order.
  - Pixel bytes 0xA5,0x3C → `wData`=0xA53C.
  - `frame_done` twice; `frame_cnt`=2; no `frame_err`.
- `cap_en`=0 at frame start, raised mid-frame.
  - Required: zero writes that frame and no pulse.
  - Next frame captured normally.
- Line 5 has 318 pixels.
  - Required: line 6 first write at `wAddr`=1920.
  - `frame_err` pulses at frame end; `frame_cnt` unchanged.
- Line with 641 bytes.
  - Required: only 320 writes on that line (none at x ≥ 320); `frame_err`.
- Assert `reset_n` at line 100 of a frame.
  - Required: all outputs 0 immediately.
  - No writes until after the next full VSYNC pulse.
  - Following frame captured clean.
- 241 lines in a frame.
  - Required: no write at `wAddr` ≥ 76800; `frame_err` pulses.
